// File: rtl/lsu_ecc_scrub.sv
// lsu_ecc_scrub: captures corrected single-bit DCCM ECC errors as they leave
// dc3 and queues write-backs of the corrected data to scrub the DCCM.
//
// Configuration macro: RV_ECC_SCRUB_CNT_EN
//   defined   -> scrub_cnt counts enqueued entries (saturating at 16'hFFFF)
//   undefined -> scrub_cnt is tied to zero and no counter flops exist
//
// Handshake: scrub_wr_req is asserted while the queue holds an entry.
// scrub_wr_addr/scrub_wr_data show the head entry and hold steady until a
// cycle with scrub_wr_req & dccm_wr_gnt, which retires exactly one entry.
// dccm_wr_gnt is ignored whenever scrub_wr_req is low.
module lsu_ecc_scrub #(
    parameter int DCCM_BITS = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 single_ecc_error_hi_dc3,
    input  logic                 single_ecc_error_lo_dc3,
    input  logic                 lsu_double_ecc_error_dc3,
    input  logic [31:0]          store_ecc_datafn_hi_dc3,
    input  logic [31:0]          store_ecc_datafn_lo_dc3,
    input  logic [DCCM_BITS-1:0] lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0] end_addr_dc3,
    input  logic                 flush_dc4,
    input  logic                 flush_dc5,
    input  logic                 dccm_wr_gnt,
    output logic                 scrub_wr_req,
    output logic [DCCM_BITS-1:0] scrub_wr_addr,
    output logic [31:0]          scrub_wr_data,
    output logic                 scrub_busy,
    output logic                 scrub_ovf,
    output logic [15:0]          scrub_cnt,
    output logic                 scrub_fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DCCM_BITS + 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Word-align the bank addresses; masking keeps every input bit in use.
    localparam logic [DCCM_BITS-1:0] WORD_MASK = ~DCCM_BITS'(3);

    logic                 dc4_err_hi, dc4_err_lo;
    logic [31:0]          dc4_data_hi, dc4_data_lo;
    logic [DCCM_BITS-1:0] dc4_addr_hi, dc4_addr_lo;
    logic                 dc5_err_hi, dc5_err_lo;
    logic [31:0]          dc5_data_hi, dc5_data_lo;
    logic [DCCM_BITS-1:0] dc5_addr_hi, dc5_addr_lo;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    state_t           state, state_next;

    logic             enq_lo, enq_hi, deq, accept;
    logic [1:0]       n_need, n_acc;
    logic [CNT_W:0]   free_slots;
    logic [ENT_W-1:0] head;

    // Pipeline the error report through dc4 and dc5; a flush kills the stage's valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc4_err_hi  <= 1'b0;
            dc4_err_lo  <= 1'b0;
            dc4_data_hi <= '0;
            dc4_data_lo <= '0;
            dc4_addr_hi <= '0;
            dc4_addr_lo <= '0;
            dc5_err_hi  <= 1'b0;
            dc5_err_lo  <= 1'b0;
            dc5_data_hi <= '0;
            dc5_data_lo <= '0;
            dc5_addr_hi <= '0;
            dc5_addr_lo <= '0;
        end else begin
            dc4_err_hi  <= single_ecc_error_hi_dc3 & ~lsu_double_ecc_error_dc3;
            dc4_err_lo  <= single_ecc_error_lo_dc3 & ~lsu_double_ecc_error_dc3;
            dc4_data_hi <= store_ecc_datafn_hi_dc3;
            dc4_data_lo <= store_ecc_datafn_lo_dc3;
            dc4_addr_hi <= end_addr_dc3 & WORD_MASK;
            dc4_addr_lo <= lsu_addr_dc3 & WORD_MASK;
            dc5_err_hi  <= dc4_err_hi & ~flush_dc4;
            dc5_err_lo  <= dc4_err_lo & ~flush_dc4;
            dc5_data_hi <= dc4_data_hi;
            dc5_data_lo <= dc4_data_lo;
            dc5_addr_hi <= dc4_addr_hi;
            dc5_addr_lo <= dc4_addr_lo;
        end
    end

    // Enqueue/dequeue decision: an access is all-or-nothing, and a same-cycle
    // dequeue frees a slot for it.
    always_comb begin
        enq_lo     = dc5_err_lo & ~flush_dc5;
        enq_hi     = dc5_err_hi & ~flush_dc5;
        n_need     = {1'b0, enq_lo} + {1'b0, enq_hi};
        deq        = (state == REQ) & dccm_wr_gnt;
        free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(deq);
        accept     = free_slots >= (CNT_W+1)'(n_need);
        n_acc      = accept ? n_need : 2'd0;
        count_next = count + CNT_W'(n_acc) - CNT_W'(deq);
    end

    // Queue storage; lo goes in ahead of hi. Contents need no reset since the
    // outputs are gated by scrub_wr_req.
    always_ff @(posedge clk) begin
        if (accept && enq_lo) begin
            mem[wr_ptr] <= {dc5_addr_lo, dc5_data_lo};
        end
        if (accept && enq_hi) begin
            mem[enq_lo ? wr_ptr + PTR_W'(1) : wr_ptr] <= {dc5_addr_hi, dc5_data_hi};
        end
    end

    // Queue pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            scrub_ovf <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_acc);
            rd_ptr <= rd_ptr + PTR_W'(deq);
            count  <= count_next;
            if (!accept) begin
                scrub_ovf <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: look at the post-update count so a fresh entry raises
    // the request on the same edge it is written.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (count_next != '0) state_next = REQ;
            REQ:  if (deq && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write-back outputs come straight from the head entry.
    always_comb begin
        head            = mem[rd_ptr];
        scrub_wr_req    = (state == REQ);
        scrub_wr_addr   = scrub_wr_req ? head[ENT_W-1:32] : '0;
        scrub_wr_data   = scrub_wr_req ? head[31:0] : '0;
        scrub_busy      = (count != '0);
        scrub_fsm_state = state;
    end

`ifdef RV_ECC_SCRUB_CNT_EN
    logic [15:0] cnt_q;
    logic [16:0] cnt_sum;

    assign cnt_sum = {1'b0, cnt_q} + 17'(n_acc);

    // Corrected-error counter, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_sum[16]) begin
            cnt_q <= 16'hFFFF;
        end else begin
            cnt_q <= cnt_sum[15:0];
        end
    end

    assign scrub_cnt = cnt_q;
`else
    assign scrub_cnt = '0;
`endif

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Bench for lsu_ecc_scrub: scenario tasks drive accesses, push expected
// write-backs into exp_q, and a monitor pops/compares on every granted write.
module tb_lsu_ecc_scrub;

    localparam int W = 48;

    logic        clk;
    logic        rst;
    logic        single_ecc_error_hi_dc3;
    logic        single_ecc_error_lo_dc3;
    logic        lsu_double_ecc_error_dc3;
    logic [31:0] store_ecc_datafn_hi_dc3;
    logic [31:0] store_ecc_datafn_lo_dc3;
    logic [15:0] lsu_addr_dc3;
    logic [15:0] end_addr_dc3;
    logic        flush_dc4;
    logic        flush_dc5;
    logic        dccm_wr_gnt;
    logic        scrub_wr_req;
    logic [15:0] scrub_wr_addr;
    logic [31:0] scrub_wr_data;
    logic        scrub_busy;
    logic        scrub_ovf;
    logic [15:0] scrub_cnt;
    logic        scrub_fsm_state;

    logic [W-1:0] exp_q[$];
    int           n_compared;
    int           n_mismatched;
    logic [15:0]  exp_cnt;

    lsu_ecc_scrub #(.DCCM_BITS(16), .DEPTH(4)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .single_ecc_error_hi_dc3  (single_ecc_error_hi_dc3),
        .single_ecc_error_lo_dc3  (single_ecc_error_lo_dc3),
        .lsu_double_ecc_error_dc3 (lsu_double_ecc_error_dc3),
        .store_ecc_datafn_hi_dc3  (store_ecc_datafn_hi_dc3),
        .store_ecc_datafn_lo_dc3  (store_ecc_datafn_lo_dc3),
        .lsu_addr_dc3             (lsu_addr_dc3),
        .end_addr_dc3             (end_addr_dc3),
        .flush_dc4                (flush_dc4),
        .flush_dc5                (flush_dc5),
        .dccm_wr_gnt              (dccm_wr_gnt),
        .scrub_wr_req             (scrub_wr_req),
        .scrub_wr_addr            (scrub_wr_addr),
        .scrub_wr_data            (scrub_wr_data),
        .scrub_busy               (scrub_busy),
        .scrub_ovf                (scrub_ovf),
        .scrub_cnt                (scrub_cnt),
        .scrub_fsm_state          (scrub_fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard monitor: each granted write-back must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && scrub_wr_req && dccm_wr_gnt) begin
            logic [W-1:0] e;
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL wb_unexpected: got addr=%h data=%h, expected no write", scrub_wr_addr, scrub_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({scrub_wr_addr, scrub_wr_data} !== e) begin
                    n_mismatched++;
                    $display("FAIL wb_entry: got addr=%h data=%h, expected addr=%h data=%h",
                             scrub_wr_addr, scrub_wr_data, e[W-1:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic void expect_entry(input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back({a & 16'hFFFC, d});
`ifdef RV_ECC_SCRUB_CNT_EN
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
    endfunction

    task automatic clear_inputs();
        single_ecc_error_hi_dc3  = 1'b0;
        single_ecc_error_lo_dc3  = 1'b0;
        lsu_double_ecc_error_dc3 = 1'b0;
        flush_dc4                = 1'b0;
        flush_dc5                = 1'b0;
    endtask

    // Drive one dc3 access for the current cycle; caller positions time.
    task automatic drive_access(input logic lo, input logic hi, input logic dbl,
                                input logic [15:0] a, input logic [15:0] ea,
                                input logic [31:0] dl, input logic [31:0] dh);
        single_ecc_error_lo_dc3  = lo;
        single_ecc_error_hi_dc3  = hi;
        lsu_double_ecc_error_dc3 = dbl;
        lsu_addr_dc3             = a;
        end_addr_dc3             = ea;
        store_ecc_datafn_lo_dc3  = dl;
        store_ecc_datafn_hi_dc3  = dh;
    endtask

    task automatic drain(input string name);
        int budget;
        repeat (3) @(posedge clk);
        #1 dccm_wr_gnt = 1'b1;
        budget = 0;
        while (scrub_busy && budget < 40) begin
            @(posedge clk);
            #1 budget++;
        end
        dccm_wr_gnt = 1'b0;
        n_compared++;
        if (scrub_busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s_drain_timeout: busy=%b, expected 0", name, scrub_busy);
        end
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL %s_drain_left: %0d expected writes missing, expected 0", name, exp_q.size());
        end
        n_compared++;
        if (scrub_cnt !== exp_cnt) begin
            n_mismatched++;
            $display("FAIL %s_cnt: got %0d, expected %0d", name, scrub_cnt, exp_cnt);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        dccm_wr_gnt = 1'b0;
        clear_inputs();
        drive_access(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
        #3;
        n_compared++;
        if ({scrub_wr_req, scrub_busy, scrub_ovf} !== 3'b000) begin
            n_mismatched++;
            $display("FAIL reset_flags: got req/busy/ovf=%b, expected 000", {scrub_wr_req, scrub_busy, scrub_ovf});
        end
        n_compared++;
        if ({scrub_wr_addr, scrub_wr_data} !== 48'h0) begin
            n_mismatched++;
            $display("FAIL reset_bus: got addr=%h data=%h, expected 0", scrub_wr_addr, scrub_wr_data);
        end
        n_compared++;
        if (scrub_cnt !== 16'h0) begin
            n_mismatched++;
            $display("FAIL reset_cnt: got %0d, expected 0", scrub_cnt);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({scrub_wr_req, scrub_busy, scrub_fsm_state} !== 3'b000) begin
            n_mismatched++;
            $display("FAIL reset_release: got req/busy/state=%b, expected 000", {scrub_wr_req, scrub_busy, scrub_fsm_state});
        end
    endtask

    task automatic test_lo_single();
        @(posedge clk);
        #1 drive_access(1'b1, 1'b0, 1'b0, 16'h0106, 16'h0109, 32'hDEADBEEF, 32'h12345678);  // N
        expect_entry(16'h0106, 32'hDEADBEEF);
        @(posedge clk);
        #1 clear_inputs();                                                              // N+1
        @(posedge clk);                                                                 // N+2
        @(negedge clk);
        n_compared++;
        if (scrub_wr_req !== 1'b0) begin
            n_mismatched++;
            $display("FAIL lo_single_early: req=%b at N+2, expected 0", scrub_wr_req);
        end
        @(posedge clk);                                                                 // N+3
        @(negedge clk);
        n_compared++;
        if ({scrub_wr_req, scrub_busy, scrub_wr_addr, scrub_wr_data} !== {2'b11, 16'h0104, 32'hDEADBEEF}) begin
            n_mismatched++;
            $display("FAIL lo_single_req: got req=%b busy=%b addr=%h data=%h, expected 1 1 0104 deadbeef",
                     scrub_wr_req, scrub_busy, scrub_wr_addr, scrub_wr_data);
        end
        @(posedge clk);                                                                 // N+4
        @(posedge clk);
        #1 dccm_wr_gnt = 1'b1;                                                          // N+5
        @(posedge clk);
        #1 dccm_wr_gnt = 1'b0;                                                          // N+6
        @(negedge clk);
        n_compared++;
        if ({scrub_wr_req, scrub_busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL lo_single_done: got req/busy=%b, expected 00", {scrub_wr_req, scrub_busy});
        end
        n_compared++;
        if (scrub_cnt !== exp_cnt) begin
            n_mismatched++;
            $display("FAIL lo_single_cnt: got %0d, expected %0d", scrub_cnt, exp_cnt);
        end
    endtask

    task automatic test_hi_lo();
        @(posedge clk);
        #1 drive_access(1'b1, 1'b1, 1'b0, 16'h0006, 16'h0009, 32'hA5A5_0001, 32'h5A5A_0002);
        expect_entry(16'h0006, 32'hA5A5_0001);
        expect_entry(16'h0009, 32'h5A5A_0002);
        @(posedge clk);
        #1 clear_inputs();
        drain("hi_lo");
    endtask

    task automatic watch_quiet(input string name, input logic [15:0] cnt_before);
        logic saw;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (scrub_wr_req || scrub_busy) saw = 1'b1;
        end
        n_compared++;
        if (saw !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s: req/busy seen=%b, expected 0", name, saw);
        end
        n_compared++;
        if (scrub_cnt !== cnt_before) begin
            n_mismatched++;
            $display("FAIL %s_cnt: got %0d, expected %0d", name, scrub_cnt, cnt_before);
        end
    endtask

    task automatic test_kill();
        // double error masks the single
        @(posedge clk);
        #1 drive_access(1'b1, 1'b1, 1'b1, 16'h0200, 16'h0204, 32'h1111_1111, 32'h2222_2222);
        @(posedge clk);
        #1 clear_inputs();
        watch_quiet("kill_double", exp_cnt);
        // flushed in its dc5 cycle
        @(posedge clk);
        #1 drive_access(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0304, 32'h3333_3333, 32'h0);
        @(posedge clk);
        #1 clear_inputs();
        @(posedge clk);
        #1 flush_dc5 = 1'b1;
        @(posedge clk);
        #1 flush_dc5 = 1'b0;
        watch_quiet("kill_flush_dc5", exp_cnt);
        // flushed in its dc4 cycle
        @(posedge clk);
        #1 drive_access(1'b0, 1'b1, 1'b0, 16'h0400, 16'h0404, 32'h0, 32'h4444_4444);
        @(posedge clk);
        #1 clear_inputs();
        flush_dc4 = 1'b1;
        @(posedge clk);
        #1 flush_dc4 = 1'b0;
        watch_quiet("kill_flush_dc4", exp_cnt);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 2; k++) begin
                logic        lo, hi;
                logic [15:0] a, ea;
                logic [31:0] dl, dh;
                lo = 1'($urandom_range(0, 1));
                hi = lo ? 1'($urandom_range(0, 1)) : 1'b1;
                a  = 16'($urandom_range(0, 16'hFFFF));
                ea = 16'($urandom_range(0, 16'hFFFF));
                dl = $urandom();
                dh = $urandom();
                @(posedge clk);
                #1 drive_access(lo, hi, 1'b0, a, ea, dl, dh);
                if (lo) expect_entry(a, dl);
                if (hi) expect_entry(ea, dh);
            end
            @(posedge clk);
            #1 clear_inputs();
            drain("back_to_back");
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            d = $urandom();
            @(posedge clk);
            #1 drive_access(1'b1, 1'b0, 1'b0, 16'(16'h0800 + 16'(i * 4)), 16'h0, d, 32'h0);
            if (i < 4) expect_entry(16'(16'h0800 + 16'(i * 4)), d);
        end
        @(posedge clk);
        #1 clear_inputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if ({scrub_wr_req, scrub_busy, scrub_ovf} !== 3'b111) begin
            n_mismatched++;
            $display("FAIL overflow_flags: got req/busy/ovf=%b, expected 111", {scrub_wr_req, scrub_busy, scrub_ovf});
        end
        // queue full; one grant lands in the same cycle the new error is in dc5
        @(posedge clk);
        #1 drive_access(1'b1, 1'b0, 1'b0, 16'h0A02, 16'h0, 32'hCAFE_F00D, 32'h0);  // N
        expect_entry(16'h0A02, 32'hCAFE_F00D);
        @(posedge clk);
        #1 clear_inputs();                                                          // N+1
        @(posedge clk);
        #1 dccm_wr_gnt = 1'b1;                                                      // N+2
        @(posedge clk);
        #1 dccm_wr_gnt = 1'b0;                                                      // N+3
        @(negedge clk);
        n_compared++;
        if ({scrub_busy, scrub_ovf} !== 2'b11) begin
            n_mismatched++;
            $display("FAIL overflow_full_swap: got busy/ovf=%b, expected 11", {scrub_busy, scrub_ovf});
        end
        drain("overflow");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 drive_access(1'b1, 1'b0, 1'b0, 16'(16'h0C00 + 16'(i * 4)), 16'h0, $urandom(), 32'h0);
        end
        @(posedge clk);
        #1 clear_inputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if ({scrub_wr_req, scrub_busy} !== 2'b11) begin
            n_mismatched++;
            $display("FAIL reset_mid_pre: got req/busy=%b, expected 11", {scrub_wr_req, scrub_busy});
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if ({scrub_wr_req, scrub_busy, scrub_ovf, scrub_cnt} !== 19'h0) begin
            n_mismatched++;
            $display("FAIL reset_mid_async: got req=%b busy=%b ovf=%b cnt=%0d, expected all 0",
                     scrub_wr_req, scrub_busy, scrub_ovf, scrub_cnt);
        end
        n_compared++;
        if ({scrub_wr_addr, scrub_wr_data} !== 48'h0) begin
            n_mismatched++;
            $display("FAIL reset_mid_bus: got addr=%h data=%h, expected 0", scrub_wr_addr, scrub_wr_data);
        end
        exp_q.delete();
        exp_cnt = 16'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        watch_quiet("reset_mid_discard", 16'h0);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        exp_cnt      = 16'h0;
        test_reset();
        test_lo_single();
        test_hi_lo();
        test_kill();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
